// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data RAM.
// Port 0 is the CPU data port, port 1 the loader/debug port; lock holds ownership for bursts.
module dmem_arbiter #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [31:0]   addr0,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  input  logic [3:0]    wen0,
  input  logic [3:0]    wen1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic          err0,
  output logic          err1,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wen,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;

  logic        any_gnt;
  logic        in_range;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wen;
  logic        unused_addr_lsb;

  logic        vld_p1;
  logic        port_p1;
  logic        rd_p1;
  logic        err_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FREE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Lock is only consulted for the port that was just granted or that owns the RAM.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      last_gnt_d = 1'b0;
    end else if (gnt1) begin
      last_gnt_d = 1'b1;
    end
    unique case (state_q)
      FREE: begin
        if (gnt0 && lock0) begin
          state_d = OWN0;
        end else if (gnt1 && lock1) begin
          state_d = OWN1;
        end
      end
      OWN0:    if (!lock0) state_d = FREE;
      OWN1:    if (!lock1) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // Grants are forced low while reset is asserted so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FREE: begin
          if (req0 && req1) begin
            gnt0 = last_gnt_q;
            gnt1 = !last_gnt_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN0:    gnt0 = req0;
        OWN1:    gnt1 = req1;
        default: ;
      endcase
    end
  end

  assign any_gnt         = gnt0 | gnt1;
  assign sel_addr        = gnt1 ? addr1  : addr0;
  assign sel_wdata       = gnt1 ? wdata1 : wdata0;
  assign sel_wen         = gnt1 ? wen1   : wen0;
  assign unused_addr_lsb = ^sel_addr[1:0];
  assign in_range        = ({2'b00, sel_addr[31:2]} < 32'(MEM_WORDS));

  assign mem_en    = any_gnt & in_range;
  assign mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
  assign mem_wdata = mem_en ? sel_wdata : '0;
  assign mem_wen   = mem_en ? sel_wen : '0;

  // ---- stage p1: response metadata, aligned with the RAM read latency ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      port_p1 <= 1'b0;
      rd_p1   <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1  <= any_gnt;
      port_p1 <= gnt1;
      rd_p1   <= (sel_wen == 4'b0000);
      err_p1  <= !in_range;
    end
  end

  assign rvalid0 = vld_p1 & ~port_p1;
  assign rvalid1 = vld_p1 &  port_p1;
  assign err0    = rvalid0 & err_p1;
  assign err1    = rvalid1 & err_p1;
  assign rdata0  = (rvalid0 && rd_p1 && !err_p1) ? mem_rdata : '0;
  assign rdata1  = (rvalid1 && rd_p1 && !err_p1) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner case, then random traffic
// checked against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;
  localparam int MEM_WORDS = 1024;
  localparam int AW        = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, lock0, lock1;
  logic [31:0]   addr0, addr1, wdata0, wdata1;
  logic [3:0]    wen0, wen1;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0]   rdata0, rdata1;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wen;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wen0(wen0), .wen1(wen1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    case (i)
      4:       return 32'hDEADBEEF;
      5:       return 32'h11110005;
      6:       return 32'h11110006;
      7:       return 32'h11110007;
      12:      return 32'h1111000C;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic        ld_en;
  logic [31:0] ram [MEM_WORDS];
  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < MEM_WORDS; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_wen == 4'b0000) mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          m_owner, m_last, m_pend;
  logic        m_perr;
  logic [31:0] m_prdata;
  logic [31:0] ref_mem [MEM_WORDS];

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_last   = 1;
    m_pend   = -1;
    m_perr   = 1'b0;
    m_prdata = '0;
  endtask

  // One clock cycle: inputs already applied; check against the model, advance it.
  task automatic step(output int g);
    logic [31:0] a, d, idx;
    logic [3:0]  w;
    logic        inr;
    logic        lk_own, lk_g;
    #1;
    if (m_owner >= 0)         g = ((m_owner == 0) ? req0 : req1) ? m_owner : -1;
    else if (req0 && req1)    g = 1 - m_last;
    else if (req0)            g = 0;
    else if (req1)            g = 1;
    else                      g = -1;
    a   = (g == 1) ? addr1  : addr0;
    d   = (g == 1) ? wdata1 : wdata0;
    w   = (g == 1) ? wen1   : wen0;
    idx = a >> 2;
    inr = (g >= 0) && (idx < MEM_WORDS);
    chk1("gnt0", gnt0, g == 0);
    chk1("gnt1", gnt1, g == 1);
    chk1("mem_en", mem_en, inr);
    chk32("mem_addr", 32'(mem_addr), inr ? idx : 32'h0);
    chk32("mem_wen", 32'(mem_wen), inr ? 32'(w) : 32'h0);
    chk32("mem_wdata", mem_wdata, inr ? d : 32'h0);
    chk1("rvalid0", rvalid0, m_pend == 0);
    chk1("rvalid1", rvalid1, m_pend == 1);
    chk1("err0", err0, (m_pend == 0) && m_perr);
    chk1("err1", err1, (m_pend == 1) && m_perr);
    chk32("rdata0", rdata0, (m_pend == 0) ? m_prdata : 32'h0);
    chk32("rdata1", rdata1, (m_pend == 1) ? m_prdata : 32'h0);
    m_pend   = g;
    m_perr   = !inr;
    m_prdata = (inr && w == 4'b0000) ? ref_mem[idx[AW-1:0]] : 32'h0;
    if (inr)
      for (int b = 0; b < 4; b++)
        if (w[b]) ref_mem[idx[AW-1:0]][8*b +: 8] = d[8*b +: 8];
    lk_own = (m_owner == 0) ? lock0 : lock1;
    lk_g   = (g == 0) ? lock0 : lock1;
    if (g >= 0) m_last = g;
    if (m_owner >= 0) begin
      if (!lk_own) m_owner = -1;
    end else if (g >= 0 && lk_g) begin
      m_owner = g;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic r0, r1, l0, l1;
    logic [31:0] a0, a1;
    logic [3:0]  w0, w1;
    logic [31:0] d0, d1;
    int          g;
    logic        en;
    logic [31:0] ma;
    logic [3:0]  mw;
    logic [31:0] md;
    int          rv;
    logic        er;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          g;
    logic        p_act [2];
    logic [31:0] p_a [2], p_d [2];
    logic [3:0]  p_w [2];

    // r0 r1 l0 l1 a0 a1 w0 w1 d0 d1 | gnt en maddr mwen mwdata | rsp_port err rdata
    vecs[0]  = '{1,1,0,0, 32'h10, 32'h14, 4'h0, 4'h0, 0, 0,                    0, 1, 4,  4'h0, 0,            -1, 0, 0};
    vecs[1]  = '{1,1,0,0, 32'h18, 32'h14, 4'h0, 4'h0, 0, 0,                    1, 1, 5,  4'h0, 0,             0, 0, 32'hDEADBEEF};
    vecs[2]  = '{1,1,0,0, 32'h18, 32'h1C, 4'h0, 4'h0, 0, 0,                    0, 1, 6,  4'h0, 0,             1, 0, 32'h11110005};
    vecs[3]  = '{1,1,0,0, 32'h22, 32'h1C, 4'h4, 4'h0, 32'h00AB0000, 0,         1, 1, 7,  4'h0, 0,             0, 0, 32'h11110006};
    vecs[4]  = '{1,0,0,0, 32'h22, 32'h0,  4'h4, 4'h0, 32'h00AB0000, 0,         0, 1, 8,  4'h4, 32'h00AB0000,  1, 0, 32'h11110007};
    vecs[5]  = '{1,1,0,1, 32'h30, 32'h0,  4'h0, 4'hF, 0, 32'hA0A0A000,         1, 1, 0,  4'hF, 32'hA0A0A000,  0, 0, 0};
    vecs[6]  = '{1,1,0,1, 32'h30, 32'h4,  4'h0, 4'hF, 0, 32'hA0A0A004,         1, 1, 1,  4'hF, 32'hA0A0A004,  1, 0, 0};
    vecs[7]  = '{1,1,0,0, 32'h30, 32'h8,  4'h0, 4'hF, 0, 32'hA0A0A008,         1, 1, 2,  4'hF, 32'hA0A0A008,  1, 0, 0};
    vecs[8]  = '{1,0,0,0, 32'h30, 32'h0,  4'h0, 4'h0, 0, 0,                    0, 1, 12, 4'h0, 0,             1, 0, 0};
    vecs[9]  = '{1,0,0,0, 32'h1000, 32'h0, 4'h0, 4'h0, 0, 0,                   0, 0, 0,  4'h0, 0,             0, 0, 32'h1111000C};
    vecs[10] = '{1,0,0,0, 32'h2000, 32'h0, 4'hF, 4'h0, 32'h12345678, 0,        0, 0, 0,  4'h0, 0,             0, 1, 0};
    vecs[11] = '{0,0,0,0, 32'h0,  32'h0,  4'h0, 4'h0, 0, 0,                   -1, 0, 0,  4'h0, 0,             0, 1, 0};
    vecs[12] = '{0,1,1,0, 32'h0,  32'h10, 4'h0, 4'h0, 0, 0,                    1, 1, 4,  4'h0, 0,            -1, 0, 0};
    vecs[13] = '{0,1,0,0, 32'h0,  32'h14, 4'h0, 4'h0, 0, 0,                    1, 1, 5,  4'h0, 0,             1, 0, 32'hDEADBEEF};
    vecs[14] = '{0,0,0,0, 32'h0,  32'h0,  4'h0, 4'h0, 0, 0,                   -1, 0, 0,  4'h0, 0,             1, 0, 32'h11110005};

    rst_n = 1'b0; ld_en = 1'b1;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; wen0 = 0; wen1 = 0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    model_reset();

    // ---- reset state: requests are ignored while rst_n is low ----
    @(negedge clk);
    req0 = 1; req1 = 1; addr0 = 32'h10;
    #1;
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    @(negedge clk);
    ld_en = 1'b0; req0 = 0; req1 = 0; addr0 = 0; rst_n = 1'b1;

    // ---- directed vector table ----
    for (int i = 0; i < 15; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1; lock0 = vecs[i].l0; lock1 = vecs[i].l1;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1; wen0 = vecs[i].w0; wen1 = vecs[i].w1;
      wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
      #1;
      chk1($sformatf("v%0d_gnt0", i), gnt0, vecs[i].g == 0);
      chk1($sformatf("v%0d_gnt1", i), gnt1, vecs[i].g == 1);
      chk1($sformatf("v%0d_mem_en", i), mem_en, vecs[i].en);
      chk32($sformatf("v%0d_mem_addr", i), 32'(mem_addr), vecs[i].ma);
      chk32($sformatf("v%0d_mem_wen", i), 32'(mem_wen), 32'(vecs[i].mw));
      chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].md);
      chk1($sformatf("v%0d_rvalid0", i), rvalid0, vecs[i].rv == 0);
      chk1($sformatf("v%0d_rvalid1", i), rvalid1, vecs[i].rv == 1);
      chk1($sformatf("v%0d_err", i), err0 | err1, vecs[i].er);
      chk32($sformatf("v%0d_rdata", i), rdata0 | rdata1, vecs[i].rd);
      step(g);
    end
    chk32("ram_word0", ram[0], 32'hA0A0A000);
    chk32("ram_word1", ram[1], 32'hA0A0A004);
    chk32("ram_word2", ram[2], 32'hA0A0A008);
    chk32("ram_word8", ram[8], 32'h00AB0000);

    // ---- reset in the middle of a response ----
    req0 = 1; addr0 = 32'h10; wen0 = 0; wdata0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    step(g);
    req0 = 0;
    #1;
    chk1("mid_rvalid_before", rvalid0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("mid_rvalid_after", rvalid0, 1'b0);
    chk32("mid_rdata_after", rdata0, 32'h0);
    chk1("mid_err_after", err0, 1'b0);
    req0 = 1; req1 = 1; addr1 = 32'h18;
    #1;
    chk1("mid_rst_gnt", gnt0 | gnt1, 1'b0);
    chk1("mid_rst_mem_en", mem_en, 1'b0);
    @(posedge clk);
    #1;
    chk1("mid_rst_gnt_edge", gnt0 | gnt1, 1'b0);
    chk1("mid_rst_rvalid_edge", rvalid0 | rvalid1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    addr0 = 32'h14;
    #1;
    chk1("post_rst_first_gnt0", gnt0, 1'b1);
    step(g);
    req0 = 0; req1 = 0;
    step(g);
    step(g);

    // ---- randomized traffic ----
    p_act[0] = 0; p_act[1] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_act[p] && $urandom_range(0, 9) < 6) begin
          p_act[p] = 1'b1;
          p_a[p] = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4300));
          p_w[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
          p_d[p] = $urandom;
        end
      end
      req0 = p_act[0]; addr0 = p_a[0]; wen0 = p_w[0]; wdata0 = p_d[0];
      req1 = p_act[1]; addr1 = p_a[1]; wen1 = p_w[1]; wdata1 = p_d[1];
      lock0 = ($urandom_range(0, 9) < 4);
      lock1 = ($urandom_range(0, 9) < 4);
      step(g);
      if (g >= 0) p_act[g] = 1'b0;
    end
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    step(g);
    step(g);
    step(g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
